lcd_pixel_fifo: RTL
===================

// Module: lcd_pixel_fifo
// PURPOSE
//  Pixel buffer between a pixel producer (valid/ready RGB565 stream) and the LCD panel pins.
//  Takes DE/HSYNC/VSYNC from the timing generator and pops one pixel per active DE cycle.
//  Drives registered, latency-matched LCD_* outputs, aligning each frame on a start-of-frame marker.
//  Reports fill level and per-frame underflow.
// PARAMETERS
//  DEPTH  1024  FIFO entries; power of two, >= 4
//  AW     10    log2(DEPTH); pointer width
// PORTS
//  PixelClk     in   1   pixel clock; all logic on rising edge
//  nRST         in   1   asynchronous, active-low reset
//  in_DE        in   1   data enable from timing generator, active high
//  in_HSYNC     in   1   hsync from timing generator, active low
//  in_VSYNC     in   1   vsync from timing generator, active low
//  s_valid      in   1   producer beat valid
//  s_ready      out  1   FIFO accepts beat when s_valid & s_ready
//  s_data       in   16  RGB565 pixel: [15:11]=R, [10:5]=G, [4:0]=B
//  s_sof        in   1   beat is first pixel of a frame
//  LCD_DE       out  1   in_DE delayed 1 cycle
//  LCD_HSYNC    out  1   in_HSYNC delayed 1 cycle
//  LCD_VSYNC    out  1   in_VSYNC delayed 1 cycle
//  LCD_R        out  5   red, aligned with LCD_DE
//  LCD_G        out  6   green, aligned with LCD_DE
//  LCD_B        out  5   blue, aligned with LCD_DE
//  level        out  AW+1  current entry count, 0..DEPTH
//  underflow    out  1   sticky: a DE cycle found FIFO empty this frame
//  frame_start  out  1   one-cycle pulse on vsync assertion
// BEHAVIOUR
//  Reset: ptrs=0, level=0, state=ALIGN; LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0,
//   underflow=0, frame_start=0. Reset mid-frame discards all contents, returns to ALIGN.
//  Vsync assertion = in_VSYNC 1->0 vs. previous-cycle sample (first cycle after reset: prev=1).
//   On that cycle: frame_start=1 next cycle, ptrs/level cleared next cycle, underflow
//   cleared, state->ALIGN; s_ready=0 during that cycle (no push).
//  States: ALIGN: s_ready=1; beats with s_sof=0 consumed and dropped; beat with s_sof=1
//   written, state->RUN. RUN: s_ready=!full; every accepted beat written (s_sof ignored).
//  Pop: when in_DE=1 and !empty. in_DE=1 with FIFO empty: no pop, output pixel = 0,
//   underflow<=1. Push into empty same cycle as DE: no write-through; counts as underflow.
//  Memory: synchronous read; popped word appears on LCD_R/G/B exactly 1 cycle after pop,
//   same cycle as LCD_DE. RGB=0 whenever LCD_DE=0 or that cycle's pop was missed.
//  Latency: all LCD_* outputs = inputs + 1 cycle, no other skew.
//  Level: push-only +1, pop-only -1, both = unchanged; full at level==DEPTH, empty at 0.
//   Pointers AW bits, wrap modulo DEPTH; level never exceeds DEPTH or goes below 0.
//  Flush and push same cycle: flush wins (s_ready=0). Flush and DE same cycle: no pop,
//   output 0, underflow not set.
// TESTING
//  Reset held low mid-frame -> LCD_HSYNC=1, LCD_VSYNC=1, LCD_DE=0, RGB=0, level=0, s_ready=1.
//  ALIGN: push 0x1234,0x5678 (sof=0), then 0xF800(sof=1),0x07E0,0x001F; 3 DE cycles ->
//   RGB = (31,0,0),(0,63,0),(0,0,31), each 1 cycle after DE; level ends 0.
//  DEPTH=16, RUN, no DE, s_valid held 20 cycles -> 16 beats accepted, s_ready=0, level=16.
//  2 pixels buffered, in_DE high 4 cycles -> 2 pixels then RGB=0 x2; underflow=1 until
//   next vsync assertion, then 0.
//  level=10, in_VSYNC 1->0 -> frame_start 1 cycle, level=0 next cycle, s_ready=0 that cycle,
//   state ALIGN (next non-sof beat dropped).
//  level=5, push+pop every cycle 100 cycles, counting data -> level stays 5, output order
//   matches input order, in_HSYNC toggles appear on LCD_HSYNC 1 cycle later.

Source files
------------

// File: rtl/lcd_pixel_fifo.sv
`default_nettype none
// ============================================================================
// lcd_pixel_fifo : RGB565 pixel FIFO feeding the LCD pins, frame-aligned on SOF
// Revision       : 1.0
// ============================================================================
module lcd_pixel_fifo #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          PixelClk,
   input  logic          nRST,
   input  logic          in_DE,
   input  logic          in_HSYNC,
   input  logic          in_VSYNC,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [15:0]   s_data,
   input  logic          s_sof,
   output logic          LCD_DE,
   output logic          LCD_HSYNC,
   output logic          LCD_VSYNC,
   output logic [4:0]    LCD_R,
   output logic [5:0]    LCD_G,
   output logic [4:0]    LCD_B,
   output logic [AW:0]   level,
   output logic          underflow,
   output logic          frame_start
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_ALIGN = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     level_q;
   logic            vsync_prev_q;
   logic            lcd_de_q, lcd_hs_q, lcd_vs_q;
   logic            pix_vld_q;
   logic [15:0]     rd_data_q;
   logic            underflow_q, frame_start_q;
   logic [15:0]     mem [DEPTH];

   logic            flush, full, empty, wr_en, pop, uf_set;

   assign flush  = vsync_prev_q & ~in_VSYNC;
   assign full   = (level_q == FULL_LVL);
   assign empty  = (level_q == '0);
   // A flush cycle never pops: the frame is being restarted.
   assign pop    = in_DE & ~empty & ~flush;
   assign uf_set = in_DE & empty & ~flush;

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) state_q <= ST_ALIGN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      wr_en   = 1'b0;
      if (flush) begin
         state_d = ST_ALIGN;
      end else begin
         case (state_q)
            ST_ALIGN: begin
               s_ready = 1'b1;
               if (s_valid && s_sof && !full) begin
                  wr_en   = 1'b1;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               s_ready = ~full;
               wr_en   = s_valid & ~full;
            end
            default: state_d = ST_ALIGN;
         endcase
      end
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_en, pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset so it maps onto block RAM.
   always_ff @(posedge PixelClk) begin
      if (wr_en) mem[wr_ptr_q] <= s_data;
      if (pop)   rd_data_q     <= mem[rd_ptr_q];
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         vsync_prev_q  <= 1'b1;
         lcd_de_q      <= 1'b0;
         lcd_hs_q      <= 1'b1;
         lcd_vs_q      <= 1'b1;
         pix_vld_q     <= 1'b0;
         underflow_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         vsync_prev_q  <= in_VSYNC;
         lcd_de_q      <= in_DE;
         lcd_hs_q      <= in_HSYNC;
         lcd_vs_q      <= in_VSYNC;
         pix_vld_q     <= pop;
         frame_start_q <= flush;
         if (flush)       underflow_q <= 1'b0;
         else if (uf_set) underflow_q <= 1'b1;
      end
   end

   assign LCD_DE      = lcd_de_q;
   assign LCD_HSYNC   = lcd_hs_q;
   assign LCD_VSYNC   = lcd_vs_q;
   assign LCD_R       = pix_vld_q ? rd_data_q[15:11] : 5'd0;
   assign LCD_G       = pix_vld_q ? rd_data_q[10:5]  : 6'd0;
   assign LCD_B       = pix_vld_q ? rd_data_q[4:0]   : 5'd0;
   assign level       = level_q;
   assign underflow   = underflow_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire
